serial_add_controller: RTL

Sequencer that wraps a 1-bit serial full adder so it can be used as a WIDTH-bit parallel adder.
- Accepts a pair of parallel operands through a valid/ready handshake.
- Feeds the operands LSB-first through the 1-bit adder cell, one bit per clock.
- Collects the sum bits and returns the parallel result plus final carry through a second valid/ready handshake.
- Sits between a parallel requester, e.g. an ALU issue stage, and the serial adder datapath.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/serial_fa_cell.sv | 32 +++
 rtl/serial_add_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; never below 1 so the counter always exists.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from logic ops, with its carry flop.
// carry_next is the combinational carry the flop will load when enabled.
module serial_fa_cell (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic carry_clr,
    input  logic carry_set,
    input  logic en,
    output logic sum,
    output logic carry_next
);

    logic carry;

    assign sum        = a ^ b ^ carry;
    assign carry_next = (a & b) | (carry & (a ^ b));

    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (carry_clr) begin
            carry <= 1'b0;
        end else if (carry_set) begin
            carry <= 1'b1;
        end else if (en) begin
            carry <= carry_next;
        end
    end

endmodule

// File: rtl/serial_add_controller.sv
// Parallel valid/ready wrapper around a bit-serial adder (LSB first, one bit per clock).
// Define SERIAL_ADD_SUB_EN to enable subtraction via in_sub.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | shifting one bit per clock through the adder cell
// DONE  | result presented, waiting for out_ready
module serial_add_controller
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0]    cnt;
    logic             accept, running, last_bit;
    logic             sum_bit, carry_next;
    logic             sub_load;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_load = in_sub;
`else
    // in_sub stays on the port list for interface stability but has no effect.
    logic sub_unused;
    assign sub_unused = in_sub;
    assign sub_load   = 1'b0;
`endif

    assign accept   = in_valid & in_ready;
    assign running  = (state == RUN);
    assign last_bit = running && (cnt == CW'(WIDTH - 1));

    serial_fa_cell u_fa (
        .clk        (clk),
        .rst        (rst),
        .a          (a_sh[0]),
        .b          (b_sh[0]),
        .carry_clr  (accept & ~sub_load),
        .carry_set  (accept & sub_load),
        .en         (running),
        .sum        (sum_bit),
        .carry_next (carry_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            cnt       <= '0;
            out_carry <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sh <= in_a;
                b_sh <= sub_load ? ~in_b : in_b;
                cnt  <= '0;
            end else if (running) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                res  <= {sum_bit, res[WIDTH-1:1]};
                cnt  <= cnt + CW'(1);
                if (last_bit) begin
                    out_carry <= carry_next;
                end
            end
        end
    end

    assign out_sum = res;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
